// File: rtl/mux_dataless.sv
// Dataless mux: joins the index token with ins[index] and forwards one token to outs.
// Latency: 0 cycles through an empty buffer; a stalled token waits in a one-slot TEHB.
// Backpressure: outs_ready reaches the join only via the registered full flag; join stalls while full.
module mux_dataless #(
    parameter int SIZE       = 2,
    parameter int INDEX_TYPE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_TYPE-1:0] index,
    input  logic                  index_valid,
    output logic                  index_ready,
    input  logic [SIZE-1:0]       ins_valid,
    output logic [SIZE-1:0]       ins_ready,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    // One-hot of the input that would be consumed together with the index token.
    logic [SIZE-1:0] sel_hit;
    // Index and its selected input are both present (in-range index only).
    logic            sel_valid;
    // The output slot can absorb a token this cycle.
    logic            buf_ready;
    // TEHB occupancy flag and its next state.
    logic            full_q;
    logic            full_d;

    // Decode the index against every input; an out-of-range code matches nothing,
    // so the protocol-error case consumes nothing and never indexes past ins_valid.
    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < SIZE; i++) begin
            sel_hit[i] = index_valid && (index == INDEX_TYPE'(i)) && ins_valid[i];
        end
    end

    // Join: index and selected input fire together, only when the buffer is empty.
    always_comb begin
        sel_valid   = |sel_hit;
        buf_ready   = !full_q;
        index_ready = sel_valid && buf_ready;
        ins_ready   = buf_ready ? sel_hit : '0;
    end

    // TEHB output: pass-through when empty, buffered token has priority when full.
    always_comb begin
        outs_valid = sel_valid || full_q;
        full_d     = (sel_valid || full_q) && !outs_ready;
    end

    // Occupancy register; reset discards any held token.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

endmodule

// File: tb/tb_mux_dataless.sv
// Directed bench for mux_dataless: SIZE=2 and SIZE=3 instances checked against a token-level model.
// Inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
// The model tracks only "a stalled token is pending" and derives every output from that.
module tb_mux_dataless;

    logic       clk;
    logic       rst;

    logic [0:0] idx2;
    logic       iv2;
    logic [1:0] insv2;
    logic       ordy2;
    logic       ir2;
    logic [1:0] insr2;
    logic       ov2;

    logic [1:0] idx3;
    logic       iv3;
    logic [2:0] insv3;
    logic       ordy3;
    logic       ir3;
    logic [2:0] insr3;
    logic       ov3;

    int checks  = 0;
    int errors  = 0;
    int pend2   = 0;
    int pend3   = 0;
    int hs3     = 0;
    bit running = 0;

    mux_dataless #(.SIZE(2), .INDEX_TYPE(1)) u2 (
        .clk(clk), .rst(rst),
        .index(idx2), .index_valid(iv2), .index_ready(ir2),
        .ins_valid(insv2), .ins_ready(insr2),
        .outs_valid(ov2), .outs_ready(ordy2)
    );

    mux_dataless #(.SIZE(3), .INDEX_TYPE(2)) u3 (
        .clk(clk), .rst(rst),
        .index(idx3), .index_valid(iv3), .index_ready(ir3),
        .ins_valid(insv3), .ins_ready(insr3),
        .outs_valid(ov3), .outs_ready(ordy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // A transfer is possible when the index is valid, in range, and its input has a token.
    function automatic int want(input int ix, input int iv, input int insv, input int size);
        if (iv != 0 && ix < size && ((insv >> ix) & 1) != 0) return 1;
        return 0;
    endfunction

    // Pending-token model: a token left unaccepted downstream is held; reset drops it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend2 <= 0;
            pend3 <= 0;
        end else begin
            if (pend2 != 0) begin
                if (ordy2) pend2 <= 0;
            end else if (want(int'(idx2), int'(iv2), int'(insv2), 2) != 0 && !ordy2) begin
                pend2 <= 1;
            end
            if (pend3 != 0) begin
                if (ordy3) pend3 <= 0;
            end else if (want(int'(idx3), int'(iv3), int'(insv3), 3) != 0 && !ordy3) begin
                pend3 <= 1;
            end
        end
    end

    // Output handshakes on the SIZE=3 instance.
    always @(posedge clk) begin
        if (!rst && ov3 && ordy3) hs3 <= hs3 + 1;
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (running) begin
            int w;
            int fire;
            w    = want(int'(idx2), int'(iv2), int'(insv2), 2);
            fire = (w != 0 && pend2 == 0) ? 1 : 0;
            chk("m2_outs_valid",  int'(ov2),   (pend2 != 0 || w != 0) ? 1 : 0);
            chk("m2_index_ready", int'(ir2),   fire);
            chk("m2_ins_ready",   int'(insr2), (fire != 0) ? (1 << int'(idx2)) : 0);
            w    = want(int'(idx3), int'(iv3), int'(insv3), 3);
            fire = (w != 0 && pend3 == 0) ? 1 : 0;
            chk("m3_outs_valid",  int'(ov3),   (pend3 != 0 || w != 0) ? 1 : 0);
            chk("m3_index_ready", int'(ir3),   fire);
            chk("m3_ins_ready",   int'(insr3), (fire != 0) ? (1 << int'(idx3)) : 0);
        end
    end

    // One cycle on the SIZE=2 instance with hand-computed expected outputs.
    task automatic cyc2(input string tag, input int ix, input int iv, input int insv, input int ordy,
                        input int e_ov, input int e_ir, input int e_insr);
        idx2  = 1'(ix);
        iv2   = 1'(iv);
        insv2 = 2'(insv);
        ordy2 = 1'(ordy);
        @(negedge clk);
        chk({tag, "_outs_valid"},  int'(ov2),   e_ov);
        chk({tag, "_index_ready"}, int'(ir2),   e_ir);
        chk({tag, "_ins_ready"},   int'(insr2), e_insr);
        @(posedge clk);
        #1;
    endtask

    // One cycle on the SIZE=3 instance with hand-computed expected outputs.
    task automatic cyc3(input string tag, input int ix, input int iv, input int insv, input int ordy,
                        input int e_ov, input int e_ir, input int e_insr);
        idx3  = 2'(ix);
        iv3   = 1'(iv);
        insv3 = 3'(insv);
        ordy3 = 1'(ordy);
        @(negedge clk);
        chk({tag, "_outs_valid"},  int'(ov3),   e_ov);
        chk({tag, "_index_ready"}, int'(ir3),   e_ir);
        chk({tag, "_ins_ready"},   int'(insr3), e_insr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b0;
        idx2  = '0; iv2 = 1'b0; insv2 = '0; ordy2 = 1'b0;
        idx3  = '0; iv3 = 1'b0; insv3 = '0; ordy3 = 1'b0;
        #1 rst = 1'b1;
        running = 1;
        @(negedge clk);
        chk("reset_outs_valid",  int'(ov2),   0);
        chk("reset_index_ready", int'(ir2),   0);
        chk("reset_ins_ready",   int'(insr2), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic pass: index 1 selects input 1 only, same cycle.
        cyc2("basic", 1, 1, 3, 1, 1, 1, 2);

        // Backpressure: token captured in cycle 0, held through the stall, drained in cycle 3.
        cyc2("bp_c0", 0, 1, 1, 0, 1, 1, 1);
        cyc2("bp_c1", 0, 1, 1, 0, 1, 0, 0);
        cyc2("bp_c2", 0, 1, 1, 0, 1, 0, 0);
        cyc2("bp_c3", 0, 1, 1, 1, 1, 0, 0);
        cyc2("bp_c4", 0, 1, 1, 1, 1, 1, 1);
        cyc2("idle2", 0, 0, 0, 1, 0, 0, 0);

        // Index waits for its data while the other input is valid.
        for (int k = 0; k < 4; k++) cyc2("wait", 1, 1, 1, 1, 0, 0, 0);
        cyc2("wait_fire", 1, 1, 3, 1, 1, 1, 2);
        cyc2("idle2b", 0, 0, 0, 1, 0, 0, 0);

        // Streaming on SIZE=3: one token per cycle, one-hot 100,001,010,100.
        cyc3("s0", 2, 1, 7, 1, 1, 1, 4);
        cyc3("s1", 0, 1, 7, 1, 1, 1, 1);
        cyc3("s2", 1, 1, 7, 1, 1, 1, 2);
        cyc3("s3", 2, 1, 7, 1, 1, 1, 4);

        // Out-of-range index stalls with nothing consumed, then recovers.
        for (int k = 0; k < 5; k++) cyc3("oor", 3, 1, 7, 1, 0, 0, 0);
        cyc3("oor_recover", 0, 1, 7, 1, 1, 1, 1);
        cyc3("idle3", 0, 0, 0, 1, 0, 0, 0);

        // Asynchronous reset while a token is buffered.
        cyc2("rst_fill", 0, 1, 1, 0, 1, 1, 1);
        iv2 = 1'b0; insv2 = '0; ordy2 = 1'b0;
        #1;
        chk("rst_held_outs_valid", int'(ov2), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_outs_valid",  int'(ov2),   0);
        chk("rst_async_index_ready", int'(ir2),   0);
        chk("rst_async_ins_ready",   int'(insr2), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outs_valid",   int'(ov2), 0);
        chk("post_rst_m3_outs_valid", int'(ov3), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("m3_handshake_total", hs3, 5);

        running = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_dataless.md
Name: mux_dataless

Overview:
- Dataless multiplexer that consumes the index token produced by a control merge.
- Steers exactly one token from the selected input channel `ins[index]` to a single output channel.
- Output path has a one-slot transparent elastic buffer (TEHB) to break the ready path.
- Sits downstream of control merges in dataless control networks, e.g. loop headers and if/else reconvergence.

Parameters:
- SIZE, 2, number of dataless input channels (≥2).
- INDEX_TYPE, 1, width of the index channel in bits; must satisfy 2^INDEX_TYPE ≥ SIZE.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- index  input  INDEX_TYPE  selector value, unsigned.
- index_valid  input  1  index channel valid.
- index_ready  output  1  index channel ready.
- ins_valid  input  SIZE  per-input valid; bit i belongs to input i.
- ins_ready  output  SIZE  per-input ready.
- outs_valid  output  1  output channel valid.
- outs_ready  input  1  output channel ready.

Behaviour:
- Reset: asynchronous, active-high; clears TEHB full flag to 0.
  - During and after reset: outs_valid=0, ins_ready=0, index_ready=0 unless the combinational join conditions below hold with an empty buffer.
- Internal signals:
  - sel_valid = index_valid AND index < SIZE AND ins_valid[index].
  - buf_ready = NOT full.
- Join (combinational):
  - index_ready = sel_valid AND buf_ready.
  - ins_ready[i] = index_valid AND (index == i) AND ins_valid[i] AND buf_ready.
  - Index token and selected input token are consumed in the same cycle, always together; never one without the other.
  - Non-selected inputs: ins_ready=0; tokens held upstream untouched.
- Out-of-range index (index ≥ SIZE): protocol error.
  - Block never consumes it: index_ready=0 and all ins_ready=0.
  - Block stalls until the index changes or reset. No X propagation.
- TEHB output stage:
  - outs_valid = sel_valid OR full.
  - full_next = (sel_valid OR full) AND NOT outs_ready.
  - Consequence: when empty and outs_ready=1, zero-cycle latency (token passes combinationally).
  - When outs_ready=0 and a join fires, the token is captured (full=1) and the join stops accepting.
  - When full, buffered token is emitted first; buf_ready=0, so no new join fires in that cycle.
  - Join may fire again from the cycle after full clears.
- Throughput: 1 token/cycle while outs_ready stays high. After a stall, one bubble-free drain, then resume.
- Valid stability: outs_valid stays high until handshake (outs_valid AND outs_ready). Guaranteed by the buffer even if upstream withdraws.
- Simultaneous events:
  - All inputs valid → only ins[index] is consumed.
  - Index arriving in the same cycle as its input → fires that cycle (no extra latency).
- Reset mid-operation: any buffered token is discarded; outs_valid drops asynchronously unless a new join is combinationally valid.
- No combinational path from outs_ready to ins_ready/index_ready; the only dependency is through the full register.

Test Plan:
- Basic pass, SIZE=2:
  - Stimulus: index=1 valid, ins_valid=2'b11, outs_ready=1.
  - Required: same cycle index_ready=1, ins_ready=2'b10, outs_valid=1; input 0 untouched.
- Backpressure:
  - Stimulus: index=0, ins_valid[0]=1, outs_ready=0 for 3 cycles, then 1.
  - Required:
    - Cycle 0: join fires, full=1.
    - Cycles 1-2: outs_valid=1, index_ready=0, ins_ready=0.
    - Cycle 3: handshake completes; full=0 at cycle 4.
- Index waits for data:
  - Stimulus: index=1 valid with ins_valid[1]=0 for 4 cycles, ins_valid[0]=1.
  - Required: outs_valid=0 and ins_ready=0 throughout; fires in the cycle ins_valid[1] rises.
- Streaming, SIZE=3, INDEX_TYPE=2:
  - Stimulus: index sequence 2,0,1,2 back-to-back, all inputs valid, outs_ready=1.
  - Required: 4 outputs in 4 consecutive cycles; ins_ready one-hot per cycle = 100,001,010,100.
- Out-of-range index, SIZE=3:
  - Stimulus: index=3 valid, ins_valid=3'b111.
  - Required: index_ready=0, ins_ready=0, outs_valid=0 indefinitely; recovers when index=0 is applied.
- Async reset while full:
  - Stimulus: assert rst mid-cycle with full=1.
  - Required: outs_valid falls before the next clock edge; after release with no valids, all outputs 0.
